// File: rtl/stopwatch_ctrl_pkg.sv
// Shared types and helpers for the stopwatch controller and its BCD converter.
package stopwatch_ctrl_pkg;

  localparam int TIMER_W    = 16;
  localparam int BCD_DIGITS = 5;
  localparam int BCD_W      = 4 * BCD_DIGITS;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RUN,
    DRAIN,
    CONVERT,
    DONE
  } state_e;

  // One double-dabble iteration: add 3 to every digit >= 5, then shift in the next binary bit.
  function automatic logic [BCD_W-1:0] dd_step(input logic [BCD_W-1:0] acc, input logic bit_in);
    logic [BCD_W-1:0] adj;
    adj = acc;
    for (int d = 0; d < BCD_DIGITS; d++) begin
      if (adj[4*d +: 4] >= 4'd5) begin
        adj[4*d +: 4] = adj[4*d +: 4] + 4'd3;
      end
    end
    return {adj[BCD_W-2:0], bit_in};
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative 16-bit binary to 5-digit BCD converter; the load cycle performs the first
// iteration so a conversion occupies exactly TIMER_W cycles, with a one-cycle done pulse.
module bin2bcd_seq
  import stopwatch_ctrl_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               load,
  input  logic [TIMER_W-1:0] bin,
  output logic [BCD_W-1:0]   bcd,
  output logic               done
);

  logic [BCD_W-1:0]   acc_q, acc_d;
  logic [TIMER_W-1:0] sh_q, sh_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               active_q, active_d;
  logic               done_q, done_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;

  always_comb begin
    acc_d    = acc_q;
    sh_d     = sh_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    done_d   = 1'b0;
    bcd_d    = bcd_q;
    if (load) begin
      acc_d    = dd_step('0, bin[TIMER_W-1]);
      sh_d     = {bin[TIMER_W-2:0], 1'b0};
      cnt_d    = 4'd1;
      active_d = 1'b1;
    end else if (active_q) begin
      acc_d = dd_step(acc_q, sh_q[TIMER_W-1]);
      sh_d  = {sh_q[TIMER_W-2:0], 1'b0};
      cnt_d = cnt_q + 4'd1;
      if (cnt_q == 4'(TIMER_W - 1)) begin
        active_d = 1'b0;
        done_d   = 1'b1;
        bcd_d    = acc_d;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      acc_q    <= '0;
      sh_q     <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
      bcd_q    <= '0;
    end else begin
      acc_q    <= acc_d;
      sh_q     <= sh_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
      done_q   <= done_d;
      bcd_q    <= bcd_d;
    end
  end

  assign bcd  = bcd_q;
  assign done = done_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Start/stop controller for the shared 16-bit timer: measures, waits for the timer to
// settle, captures the count and presents it in binary and BCD behind a valid/ack handshake.
module stopwatch_ctrl
  import stopwatch_ctrl_pkg::*;
#(
  parameter logic [TIMER_W-1:0] LIMIT      = 16'hFFFF,
  parameter int                 SETTLE_MAX = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic               abort,
  input  logic               ack,
  input  logic [TIMER_W-1:0] t_out,
  input  logic               t_valid,
  output logic               t_en,
  output logic               t_clr,
  output logic               busy,
  output logic [TIMER_W-1:0] result_bin,
  output logic [BCD_W-1:0]   result_bcd,
  output logic               result_valid,
  output logic               overflow,
  output logic               error
);

  state_e             state_q, state_d;
  logic [2:0]         settle_q, settle_d;
  logic [TIMER_W-1:0] result_bin_q, result_bin_d;
  logic [BCD_W-1:0]   result_bcd_q, result_bcd_d;
  logic               overflow_q, overflow_d;
  logic               error_q, error_d;
  logic               t_en_q, t_clr_q, busy_q, result_valid_q;
  logic               conv_load, conv_done;
  logic [BCD_W-1:0]   conv_bcd;

  bin2bcd_seq u_bin2bcd (
    .clock (clock),
    .reset (reset),
    .load  (conv_load),
    .bin   (t_out),
    .bcd   (conv_bcd),
    .done  (conv_done)
  );

  always_comb begin
    state_d      = state_q;
    settle_d     = '0;
    result_bin_d = result_bin_q;
    result_bcd_d = result_bcd_q;
    overflow_d   = overflow_q;
    error_d      = error_q;
    conv_load    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!abort && start) begin
          state_d    = CLEAR;
          overflow_d = 1'b0;
          error_d    = 1'b0;
        end
      end
      CLEAR: state_d = abort ? IDLE : RUN;
      RUN: begin
        // The timer counts on the edge leaving RUN, so stopping at LIMIT-1 lands on LIMIT.
        if (abort) begin
          state_d = IDLE;
        end else begin
          if (stop) state_d = DRAIN;
          if (t_out == LIMIT - 16'd1) begin
            state_d    = DRAIN;
            overflow_d = 1'b1;
          end
        end
      end
      DRAIN: begin
        settle_d = settle_q + 3'd1;
        if (abort) begin
          state_d = IDLE;
        end else if (!t_valid) begin
          result_bin_d = t_out;
          conv_load    = 1'b1;
          state_d      = CONVERT;
        end else if (settle_d == 3'(SETTLE_MAX)) begin
          error_d = 1'b1;
          state_d = IDLE;
        end
      end
      CONVERT: begin
        if (abort) begin
          state_d = IDLE;
        end else if (conv_done) begin
          result_bcd_d = conv_bcd;
          state_d      = DONE;
        end
      end
      DONE: begin
        if (abort) begin
          state_d = IDLE;
        end else if (start) begin
          state_d    = CLEAR;
          overflow_d = 1'b0;
          error_d    = 1'b0;
        end else if (ack) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Timer controls and status flags are registered decodes of the next state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= IDLE;
      settle_q       <= '0;
      result_bin_q   <= '0;
      result_bcd_q   <= '0;
      overflow_q     <= 1'b0;
      error_q        <= 1'b0;
      t_en_q         <= 1'b0;
      t_clr_q        <= 1'b0;
      busy_q         <= 1'b0;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      settle_q       <= settle_d;
      result_bin_q   <= result_bin_d;
      result_bcd_q   <= result_bcd_d;
      overflow_q     <= overflow_d;
      error_q        <= error_d;
      t_en_q         <= (state_d == RUN);
      t_clr_q        <= (state_d == CLEAR);
      busy_q         <= (state_d inside {CLEAR, RUN, DRAIN, CONVERT});
      result_valid_q <= (state_d == DONE);
    end
  end

  assign t_en         = t_en_q;
  assign t_clr        = t_clr_q;
  assign busy         = busy_q;
  assign result_bin   = result_bin_q;
  assign result_bcd   = result_bcd_q;
  assign result_valid = result_valid_q;
  assign overflow     = overflow_q;
  assign error        = error_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench: instance 0 has LIMIT=25, instance 1 the full 16-bit LIMIT; each has its own timer model.
module tb_stopwatch_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  rst = 2'b11;
  logic [1:0]  start = '0, stop = '0, abort = '0, ack = '0;
  logic [1:0]  t_en, t_clr, busy, result_valid, overflow, error;
  logic [15:0] result_bin [2];
  logic [19:0] result_bcd [2];

  logic [15:0] tm_out [2] = '{16'd0, 16'd0};
  logic [1:0]  tm_valid = '0;
  logic [1:0]  stuck = '0;
  logic [1:0]  cnt_rst = '0;
  int          en_cnt [2] = '{0, 0};
  int          clr_cnt [2] = '{0, 0};
  int          rv_cnt [2] = '{0, 0};

  int checks = 0;
  int errors = 0;
  int n;

  stopwatch_ctrl #(.LIMIT(16'd25), .SETTLE_MAX(4)) dut_a (
    .clock(clk), .reset(rst[0]), .start(start[0]), .stop(stop[0]), .abort(abort[0]),
    .ack(ack[0]), .t_out(tm_out[0]), .t_valid(tm_valid[0]), .t_en(t_en[0]), .t_clr(t_clr[0]),
    .busy(busy[0]), .result_bin(result_bin[0]), .result_bcd(result_bcd[0]),
    .result_valid(result_valid[0]), .overflow(overflow[0]), .error(error[0])
  );

  stopwatch_ctrl #(.LIMIT(16'hFFFF), .SETTLE_MAX(4)) dut_b (
    .clock(clk), .reset(rst[1]), .start(start[1]), .stop(stop[1]), .abort(abort[1]),
    .ack(ack[1]), .t_out(tm_out[1]), .t_valid(tm_valid[1]), .t_en(t_en[1]), .t_clr(t_clr[1]),
    .busy(busy[1]), .result_bin(result_bin[1]), .result_bcd(result_bcd[1]),
    .result_valid(result_valid[1]), .overflow(overflow[1]), .error(error[1])
  );

  // Timer model: clear wins, counts while enabled, valid is enable delayed one cycle.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (t_clr[i]) tm_out[i] <= 16'd0;
      else if (t_en[i]) tm_out[i] <= tm_out[i] + 16'd1;
      tm_valid[i] <= stuck[i] | t_en[i];
      if (cnt_rst[i]) begin
        en_cnt[i]  <= 0;
        clr_cnt[i] <= 0;
        rv_cnt[i]  <= 0;
      end else begin
        en_cnt[i]  <= en_cnt[i] + int'(t_en[i]);
        clr_cnt[i] <= clr_cnt[i] + int'(t_clr[i]);
        rv_cnt[i]  <= rv_cnt[i] + int'(result_valid[i]);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_zero(input int i, input string tag);
    check({tag, "_t_en"}, 32'(t_en[i]), 0);
    check({tag, "_t_clr"}, 32'(t_clr[i]), 0);
    check({tag, "_busy"}, 32'(busy[i]), 0);
    check({tag, "_bin"}, 32'(result_bin[i]), 0);
    check({tag, "_bcd"}, 32'(result_bcd[i]), 0);
    check({tag, "_rv"}, 32'(result_valid[i]), 0);
    check({tag, "_ovf"}, 32'(overflow[i]), 0);
    check({tag, "_err"}, 32'(error[i]), 0);
  endtask

  // Returns at the negedge after the start edge (CLEAR visible).
  task automatic pulse_start(input int i);
    cnt_rst[i] = 1'b1;
    start[i]   = 1'b1;
    @(negedge clk);
    start[i]   = 1'b0;
    cnt_rst[i] = 1'b0;
  endtask

  task automatic wait_valid(input int i, input int bound, output int cycles);
    cycles = 0;
    while (!result_valid[i] && cycles < bound) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 2'b00;
    check_zero(0, "rst_a");
    check_zero(1, "rst_b");

    // Basic measurement: stop in the 10th RUN cycle.
    pulse_start(1);
    check("clr_pulse", 32'(t_clr[1]), 1);
    check("clr_en", 32'(t_en[1]), 0);
    check("clr_busy", 32'(busy[1]), 1);
    @(negedge clk);
    check("run_clr", 32'(t_clr[1]), 0);
    check("run_en", 32'(t_en[1]), 1);
    repeat (9) @(negedge clk);
    stop[1] = 1'b1;
    @(negedge clk);
    stop[1] = 1'b0;
    wait_valid(1, 40, n);
    check("basic_lat", 32'(n), 18);
    check("basic_bin", 32'(result_bin[1]), 10);
    check("basic_bcd", 32'(result_bcd[1]), 32'h00010);
    check("basic_ovf", 32'(overflow[1]), 0);
    check("basic_err", 32'(error[1]), 0);
    check("basic_en_cycles", 32'(en_cnt[1]), 10);
    check("basic_clr_cycles", 32'(clr_cnt[1]), 1);
    $display("txn basic: bin=%0d bcd=%05h lat=%0d", result_bin[1], result_bcd[1], n);
    repeat (3) @(negedge clk);
    check("done_hold", 32'(result_valid[1]), 1);

    // Start in DONE without ack; start again mid-RUN (ignored); stop in 6th RUN cycle.
    pulse_start(1);
    check("restart_rv", 32'(result_valid[1]), 0);
    check("restart_clr", 32'(t_clr[1]), 1);
    @(negedge clk);
    repeat (2) @(negedge clk);
    start[1] = 1'b1;
    @(negedge clk);
    start[1] = 1'b0;
    check("run_start_en", 32'(t_en[1]), 1);
    check("run_start_clr", 32'(t_clr[1]), 0);
    repeat (2) @(negedge clk);
    stop[1] = 1'b1;
    @(negedge clk);
    stop[1] = 1'b0;
    wait_valid(1, 40, n);
    check("ign_lat", 32'(n), 18);
    check("ign_bin", 32'(result_bin[1]), 6);
    check("ign_bcd", 32'(result_bcd[1]), 32'h00006);
    check("ign_en_cycles", 32'(en_cnt[1]), 6);
    $display("txn start-in-run: bin=%0d bcd=%05h", result_bin[1], result_bcd[1]);
    ack[1] = 1'b1;
    @(negedge clk);
    ack[1] = 1'b0;
    check("ack_rv", 32'(result_valid[1]), 0);
    check("ack_busy", 32'(busy[1]), 0);

    // abort and stop together in RUN: no result.
    pulse_start(1);
    @(negedge clk);
    repeat (3) @(negedge clk);
    abort[1] = 1'b1;
    stop[1]  = 1'b1;
    @(negedge clk);
    abort[1] = 1'b0;
    stop[1]  = 1'b0;
    check("abort_busy", 32'(busy[1]), 0);
    check("abort_en", 32'(t_en[1]), 0);
    repeat (25) @(negedge clk);
    check("abort_no_rv", 32'(rv_cnt[1]), 0);
    check("abort_bin_kept", 32'(result_bin[1]), 6);
    check("abort_bcd_kept", 32'(result_bcd[1]), 32'h00006);
    $display("txn abort+stop: busy=%0d bin=%0d", busy[1], result_bin[1]);

    // Settle timeout with t_valid stuck high.
    stuck[1] = 1'b1;
    pulse_start(1);
    @(negedge clk);
    repeat (4) @(negedge clk);
    stop[1] = 1'b1;
    @(negedge clk);
    stop[1] = 1'b0;
    repeat (3) @(negedge clk);
    check("settle_err_early", 32'(error[1]), 0);
    check("settle_busy_early", 32'(busy[1]), 1);
    @(negedge clk);
    check("settle_err", 32'(error[1]), 1);
    check("settle_busy", 32'(busy[1]), 0);
    repeat (20) @(negedge clk);
    check("settle_no_rv", 32'(rv_cnt[1]), 0);
    check("settle_bin_kept", 32'(result_bin[1]), 6);
    stuck[1] = 1'b0;
    $display("txn settle-timeout: error=%0d bin=%0d", error[1], result_bin[1]);

    // New start clears error; reset mid-RUN.
    pulse_start(1);
    check("err_cleared", 32'(error[1]), 0);
    @(negedge clk);
    repeat (4) @(negedge clk);
    rst[1] = 1'b1;
    @(negedge clk);
    check("midrst_en", 32'(t_en[1]), 0);
    @(negedge clk);
    rst[1] = 1'b0;
    check_zero(1, "midrst");
    $display("txn mid-run reset: t_en=%0d busy=%0d", t_en[1], busy[1]);

    // Auto-stop at LIMIT=25.
    pulse_start(0);
    wait_valid(0, 100, n);
    check("lim_lat", 32'(n), 44);
    check("lim_rv", 32'(result_valid[0]), 1);
    check("lim_en_cycles", 32'(en_cnt[0]), 25);
    check("lim_bin", 32'(result_bin[0]), 25);
    check("lim_bcd", 32'(result_bcd[0]), 32'h00025);
    check("lim_ovf", 32'(overflow[0]), 1);
    check("lim_err", 32'(error[0]), 0);
    $display("txn limit25: bin=%0d bcd=%05h ovf=%0d", result_bin[0], result_bcd[0], overflow[0]);
    ack[0] = 1'b1;
    @(negedge clk);
    ack[0] = 1'b0;
    check("lim_ack_rv", 32'(result_valid[0]), 0);

    // Full range auto-stop at 65535.
    pulse_start(1);
    wait_valid(1, 70000, n);
    check("full_rv", 32'(result_valid[1]), 1);
    check("full_en_cycles", 32'(en_cnt[1]), 65535);
    check("full_bin", 32'(result_bin[1]), 65535);
    check("full_bcd", 32'(result_bcd[1]), 32'h65535);
    check("full_ovf", 32'(overflow[1]), 1);
    $display("txn full-range: bin=%0d bcd=%05h ovf=%0d", result_bin[1], result_bcd[1], overflow[1]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
- Controller for the shared 16-bit timer; drives the timer's enable and clear inputs (t_en, t_clr).
- Runs a start/stop measurement, then waits for the timer to settle (t_valid low) and captures t_out.
- Auto-stops at a programmable limit.
- Converts the captured binary count to 5-digit BCD for the display path, with a valid/ack handshake.

Parameters:
- LIMIT, 16'hFFFF, auto-stop count; legal range 1..65535.
- SETTLE_MAX, 4, cycles allowed in DRAIN for t_valid to drop before flagging error.

Ports:
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high; clears all state
- start  in  1  one-cycle pulse: begin new measurement
- stop  in  1  one-cycle pulse: end measurement
- abort  in  1  one-cycle pulse: cancel, return to IDLE, no result
- ack  in  1  consumer accepted result
- t_out  in  16  count from timer
- t_valid  in  1  timer valid (t_en delayed one cycle)
- t_en  out  1  registered enable to timer
- t_clr  out  1  registered clear to timer, one-cycle pulse
- busy  out  1  high in CLEAR/RUN/DRAIN/CONVERT
- result_bin  out  16  captured count
- result_bcd  out  20  5 BCD digits, digit 0 in [3:0]
- result_valid  out  1  high in DONE until ack
- overflow  out  1  last measurement hit LIMIT
- error  out  1  settle timeout on last measurement

Behaviour:
- Reset (synchronous):
  - state=IDLE.
  - All outputs 0: t_en, t_clr, busy, result_bin, result_bcd, result_valid, overflow, error.
- Input priority, same cycle: abort > stop > start. ack is only examined in DONE.
- IDLE:
  - start -> CLEAR.
  - overflow and error are cleared on leaving IDLE for CLEAR.
- CLEAR: exactly one cycle; t_clr=1, t_en=0; -> RUN.
- RUN:
  - t_en=1.
  - stop -> DRAIN.
  - t_out==LIMIT-1 -> DRAIN, overflow<=1.
  - abort -> IDLE.
  - The timer increments on the edge that leaves RUN, so the final count equals the number of cycles spent in RUN. With LIMIT auto-stop the final count is exactly LIMIT.
  - start in RUN is ignored.
- DRAIN:
  - t_en=0; 3-bit settle counter increments each cycle.
  - When t_valid==0: result_bin<=t_out, go to CONVERT.
  - Counter reaching SETTLE_MAX with t_valid still 1: error<=1, result_bin unchanged, go to IDLE.
  - abort -> IDLE.
- CONVERT:
  - Sequential shift-add-3 (double dabble), one bit per cycle, exactly 16 cycles.
  - Then result_bcd loads and the state goes to DONE.
  - abort -> IDLE; result_bcd keeps its old value.
- DONE:
  - result_valid=1, held stable.
  - ack -> IDLE.
  - start (with or without ack) -> CLEAR, result_valid drops the same edge.
  - abort -> IDLE.
- Outputs:
  - t_en and t_clr are registered decodes of the next state (no combinational paths from inputs).
  - busy is a registered state decode.
- Latency, stop sampled to result_valid: 1 (DRAIN, t_valid already low next cycle) + 16 (CONVERT) + 1 = result_valid high 18 cycles after the stop edge.
- reset mid-operation: immediate return to IDLE; t_en=0 on the same edge.
- result_bin, result_bcd hold their last good value until the next successful capture.
- Max count 65535 -> BCD 6_5_5_3_5, fits 20 bits.

Decomposition:
- Shared package:
  - state encoding enum (IDLE, CLEAR, RUN, DRAIN, CONVERT, DONE)
  - TIMER_W=16, BCD_DIGITS=5
- One sub-module, bin2bcd_seq:
  - Inputs: clock, reset, load, bin[15:0].
  - Outputs: bcd[19:0], done.
  - 16-cycle iterative converter; done is a one-cycle pulse.

Test Plan:
- Reset held 2 cycles mid-RUN -> t_en=0 on the next edge, state IDLE, all outputs 0.
- Basic measurement:
  - Stimulus: start pulse, stop pulse asserted in the 10th RUN cycle, timer model attached.
  - Response: t_clr high exactly 1 cycle; t_en high 10 cycles; result_bin=10, result_bcd=20'h00010; result_valid 18 cycles after the stop edge; overflow=0, error=0.
- Limit auto-stop:
  - Stimulus: LIMIT=25, start, no stop.
  - Response: t_en high 25 cycles, result_bin=25, result_bcd=20'h00025, overflow=1.
- Full range: LIMIT=16'hFFFF, start, no stop -> result_bin=65535, result_bcd=20'h65535, overflow=1.
- Settle timeout:
  - Stimulus: timer model with t_valid stuck at 1, start, stop.
  - Response: after 4 DRAIN cycles, error=1, state IDLE, result_valid never asserts, result_bin keeps its previous value.
- Handshake and priority:
  - In DONE, start without ack -> result_valid falls, new CLEAR pulse.
  - abort and stop in the same RUN cycle -> IDLE, no result.
  - start during RUN -> ignored; count continues uninterrupted.
